// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states
// and the alignment check used when a request is accepted.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

  // True when the access cannot be served at this byte offset; the illegal
  // size encoding is folded in here so one call covers both error kinds.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: lsu_misaligned = 1'b0;
      SZ_HALF: lsu_misaligned = offset[0];
      SZ_WORD: lsu_misaligned = (offset != 2'b00);
      default: lsu_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts and extends load data from a memory
// word, and merges sub-word store data into a previously read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  lsu_size_e   size_i,
  input  logic        signed_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_data_o
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Pick the addressed byte; byte k lives in bits [8k+7:8k].
  always_comb begin
    case (offset_i)
      2'd0:    lane_byte = word_i[7:0];
      2'd1:    lane_byte = word_i[15:8];
      2'd2:    lane_byte = word_i[23:16];
      default: lane_byte = word_i[31:24];
    endcase
  end

  assign lane_half = offset_i[1] ? word_i[31:16] : word_i[15:0];

  // Extend the selected lane; word accesses pass straight through.
  always_comb begin
    case (size_i)
      SZ_BYTE: load_data_o = {{24{signed_i & lane_byte[7]}}, lane_byte};
      SZ_HALF: load_data_o = {{16{signed_i & lane_half[15]}}, lane_half};
      default: load_data_o = word_i;
    endcase
  end

  // Replace only the addressed lane(s) of the read word with the new data.
  always_comb begin
    store_data_o = word_i;
    case (size_i)
      SZ_BYTE: store_data_o[{offset_i, 3'b000} +: 8]     = wdata_i[7:0];
      SZ_HALF: store_data_o[{offset_i[1], 4'b0000} +: 16] = wdata_i;
      default: store_data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU access at a time, checks it, performs a
// read, a write or a read-modify-write on a word memory, then pulses a
// response. Memory writes happen on the falling edge while mem_we is high.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q;
  lsu_size_e   size_q;
  logic        we_q;
  logic        signed_q;
  logic [1:0]  offset_q;
  logic [15:0] wdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_we_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] store_data;

  assign req_err = lsu_misaligned(req_size, req_addr[1:0]) ||
                   ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

  lsu_lane_align u_align (
    .word_i       (mem_rdata),
    .offset_i     (offset_q),
    .size_i       (size_q),
    .signed_i     (signed_q),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_data_o (store_data)
  );

  // Access sequencer; every output is a register so mem_we cannot glitch
  // and reset pulls it low immediately, cancelling a pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      size_q       <= SZ_BYTE;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      offset_q     <= 2'b00;
      wdata_q      <= 16'h0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            size_q   <= lsu_size_e'(req_size);
            we_q     <= req_we;
            signed_q <= req_signed;
            offset_q <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            if (req_err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
              state_q      <= RESP;
            end else begin
              mem_addr_q <= {2'b00, req_addr[31:2]};
              if (req_we && (req_size == SZ_WORD)) begin
                mem_wdata_q <= req_wdata;
                mem_we_q    <= 1'b1;
                state_q     <= WR;
              end else begin
                state_q <= RD;
              end
            end
          end
        end
        RD: begin
          if (we_q) begin
            mem_wdata_q <= store_data;
            mem_we_q    <= 1'b1;
            state_q     <= WR;
          end else begin
            resp_rdata_q <= load_data;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        WR: begin
          mem_we_q     <= 1'b0;
          resp_rdata_q <= 32'h0;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a word memory model, a request driver that
// pushes expected responses into a queue, and a monitor that pops them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];
  int          cycleCount = 0;
  int          weCount = 0;
  logic [31:0] lastWeAddr = 32'h0;
  int          compared = 0;
  int          mismatched = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acceptCycle;
  } exp_t;

  exp_t sb[$];
  exp_t monExp;

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Memory model: combinational read, write on the falling edge.
  assign mem_rdata = mem[mem_addr[5:0]];
  always @(negedge clk) begin
    if (mem_we) begin
      mem[mem_addr[5:0]] <= mem_wdata;
      weCount            <= weCount + 1;
      lastWeAddr         <= mem_addr;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_resp: got resp_valid=1 expected no response");
      end else begin
        monExp = sb.pop_front();
        checkOutput({monExp.name, "_rdata"}, resp_rdata, monExp.rdata);
        checkOutput({monExp.name, "_err"}, {31'h0, resp_err}, {31'h0, monExp.err});
        checkOutput({monExp.name, "_lat"}, cycleCount - monExp.acceptCycle + 1, monExp.lat);
      end
    end
  end

  task automatic driveReq(input string name, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
    int waitCnt;
    exp_t e;
    @(negedge clk);
    waitCnt = 0;
    while (!req_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!req_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_ready_timeout: got req_ready=0 expected 1", name);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic applyStimulus(input string name, input logic we, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expRdata, input logic expErr, input int expLat);
    int waitCnt;
    exp_t e;
    driveReq(name, we, size, sgn, addr, wdata);
    e.name        = name;
    e.rdata       = expRdata;
    e.err         = expErr;
    e.lat         = expLat;
    e.acceptCycle = cycleCount;
    sb.push_back(e);
    waitCnt = 0;
    while (sb.size() != 0 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_resp_timeout: got no response expected one within 20 cycles", name);
      sb.delete();
    end
  endtask

  int weBefore;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[5]     = 32'h01020304;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    #12;
    checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_resp_err", {31'h0, resp_err}, 32'h0);
    checkOutput("rst_mem_we", {31'h0, mem_we}, 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then word load at word 4.
    weBefore = weCount;
    applyStimulus("st_w_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    checkOutput("st_w_10_mem", mem[4], 32'hDEADBEEF);
    checkOutput("st_w_10_wecnt", weCount - weBefore, 1);
    checkOutput("st_w_10_weaddr", lastWeAddr, 32'h4);
    applyStimulus("ld_w_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Byte store via read-modify-write, then byte loads both extensions.
    applyStimulus("st_b_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h55, 32'h0, 1'b0, 3);
    checkOutput("st_b_11_mem", mem[4], 32'hDEAD55EF);
    applyStimulus("ld_bs_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
    applyStimulus("ld_bu_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2);
    applyStimulus("ld_bu_11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h00000055, 1'b0, 2);

    // Halfword store onto a fresh 0xDEADBEEF, then halfword loads.
    applyStimulus("st_w_10b", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    applyStimulus("st_h_12", 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 32'h0, 1'b0, 3);
    checkOutput("st_h_12_mem", mem[4], 32'h1234BEEF);
    applyStimulus("ld_hs_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, 2);
    applyStimulus("ld_hu_10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 2);
    applyStimulus("ld_hs_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00001234, 1'b0, 2);

    // Byte 0 store ignores upper data bits; signed load of 0xFF.
    applyStimulus("st_b_18", 1'b1, 2'b00, 1'b0, 32'h18, 32'h000001FF, 32'h0, 1'b0, 3);
    checkOutput("st_b_18_mem", mem[6], 32'h000000FF);
    applyStimulus("ld_bs_18", 1'b0, 2'b00, 1'b1, 32'h18, 32'h0, 32'hFFFFFFFF, 1'b0, 2);

    // Last in-range word.
    applyStimulus("st_w_fc", 1'b1, 2'b10, 1'b0, 32'hFC, 32'hA5A50F0F, 32'h0, 1'b0, 2);
    checkOutput("st_w_fc_mem", mem[63], 32'hA5A50F0F);
    applyStimulus("ld_w_fc", 1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, 32'hA5A50F0F, 1'b0, 2);

    // Error cases: no memory write, zero data, one-cycle latency.
    weBefore = weCount;
    applyStimulus("err_ld_w_02", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1, 1);
    applyStimulus("err_st_h_03", 1'b1, 2'b01, 1'b0, 32'h03, 32'h9999, 32'h0, 1'b1, 1);
    applyStimulus("err_size11", 1'b1, 2'b11, 1'b0, 32'h20, 32'h77777777, 32'h0, 1'b1, 1);
    applyStimulus("err_ld_w_100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1);
    applyStimulus("err_st_w_100", 1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, 32'h0, 1'b1, 1);
    checkOutput("err_wecnt", weCount - weBefore, 0);
    checkOutput("err_mem_w0", mem[0], 32'h0);

    // Reset during the write cycle of a byte store to word 5.
    weBefore = weCount;
    driveReq("rst_wr", 1'b1, 2'b00, 1'b0, 32'h14, 32'h77);
    @(posedge clk);
    #1;
    checkOutput("rst_wr_we_before", {31'h0, mem_we}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_wr_we_after", {31'h0, mem_we}, 32'h0);
    checkOutput("rst_wr_ready", {31'h0, req_ready}, 32'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_wr_mem", mem[5], 32'h01020304);
    checkOutput("rst_wr_wecnt", weCount - weBefore, 0);
    checkOutput("rst_wr_ready_rel", {31'h0, req_ready}, 32'h1);

    // Unit still operates after the abandoned access.
    applyStimulus("ld_bu_16", 1'b0, 2'b00, 1'b0, 32'h16, 32'h0, 32'h00000002, 1'b0, 2);
    applyStimulus("ld_hu_16", 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 32'h00000102, 1'b0, 2);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64, giving the number of addressable 32-bit words; word index >= MEM_WORDS is out of range.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  in  1  CPU access request present.
REQ-005 SHALL have port req_ready  out  1  unit idle; request accepted when req_valid&&req_ready at a rising edge.
REQ-006 SHALL have port req_we  in  1  1=store, 0=load.
REQ-007 SHALL have port req_size  in  2  00=byte, 01=halfword, 10=word, 11=illegal.
REQ-008 SHALL have port req_signed  in  1  loads: 1=sign-extend, 0=zero-extend.
REQ-009 SHALL have port req_addr  in  32  byte address.
REQ-010 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  out  1  misaligned, illegal size or out of range; qualified by resp_valid.
REQ-014 SHALL have ports mem_addr out 32 (word index), mem_wdata out 32, mem_we out 1, mem_rdata in 32 (combinational read data), toward the data memory, which writes on the falling clk edge when mem_we=1.

Function
REQ-015 SHALL implement states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-016 SHALL, on acceptance, register size, we, signed, addr, wdata; inputs are ignored outside IDLE.
REQ-017 SHALL flag error when: size=11; halfword with addr[0]=1; word with addr[1:0]!=00; or addr[31:2] >= MEM_WORDS.
REQ-018 SHALL transition IDLE->RESP on error, with no memory access (mem_we never asserted).
REQ-019 SHALL transition IDLE->RD for loads and sub-word stores, IDLE->WR for word stores.
REQ-020 SHALL, in RD, drive mem_addr={2'b00,addr[31:2]}, mem_we=0, and capture mem_rdata at the closing edge; RD->RESP for loads, RD->WR for stores.
REQ-021 SHALL, in WR, drive mem_addr and mem_wdata from registers with mem_we=1 for exactly one cycle, then go to RESP.
REQ-022 SHALL use little-endian lanes: byte k = bits [8k+7:8k], halfword at addr[1]*16.
REQ-023 SHALL form sub-word store data by read-modify-write: captured word with only the addressed lane(s) replaced by req_wdata[7:0] or [15:0].
REQ-024 SHALL extract load data from the addressed lane, then sign- or zero-extend per req_signed; word loads pass unchanged.
REQ-025 SHALL assert resp_valid for exactly the RESP cycle, then return to IDLE; resp_rdata/resp_err held until next RESP.
REQ-026 SHALL give latency from acceptance edge to resp_valid: error 1 cycle, load 2, word store 2, sub-word store 3.
REQ-027 SHALL drive mem_we only from registered state, glitch-free, so address/data are stable before the falling edge.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-029 SHALL, when reset hits mid-operation, abandon it with no response and no subsequent write; a write in WR is suppressed if rst_n falls before the falling edge.

Structure
REQ-030 SHALL place size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enumeration in shared package lsu_pkg.
REQ-031 SHALL factor lane extract/extend and merge logic into one combinational sub-module lsu_lane_align.

Verification
REQ-032 Word store addr 0x10 data 0xDEADBEEF, then word load 0x10 -> mem_we one cycle at word 4; load resp_rdata=0xDEADBEEF, resp_err=0, latency 2.
REQ-033 Word 4=0xDEADBEEF; byte store addr 0x11 data 0x55 -> word 4=0xDEAD55EF, latency 3; signed byte load 0x13 -> 0xFFFFFFDE; unsigned -> 0x000000DE.
REQ-034 Halfword store addr 0x12 data 0x1234 onto 0xDEADBEEF -> 0x1234BEEF; signed halfword load 0x10 -> 0xFFFFBEEF.
REQ-035 Word load 0x02, halfword store 0x03, size=11, word load 0x100 (MEM_WORDS=64) -> each resp_err=1, resp_rdata=0, mem_we never 1, latency 1.
REQ-036 Assert rst_n=0 during WR of a byte store -> mem_we drops at once, target word unchanged, no resp_valid, req_ready=1 after release.
